// File: rtl/demux4_pkg.sv
// demux4_pkg: shared channel count, select type and select decode for the 1-to-4 deserializer
package demux4_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W = 2;
   typedef logic [SEL_W-1:0] ch_idx_t;
   function automatic logic [NUM_CH-1:0] sel_onehot(input ch_idx_t s);
      logic [NUM_CH-1:0] one;
      one = {{(NUM_CH-1){1'b0}}, 1'b1};
      return one << s;
   endfunction
endpackage

// File: rtl/demux4_deser_ch.sv
// demux4_deser_ch: one channel deserializer with a one-word holding register and sticky overflow
module demux4_deser_ch #(
   parameter int DATA_W = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              accept,
   input  logic              in_bit,
   input  logic              flush,
   input  logic              out_ready,
   input  logic              clear_ovf,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              overflow,
   output logic              busy
);
   localparam int CW = $clog2(DATA_W);
   logic [CW-1:0] cnt, cnt_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic acc, last, load, drop;
   // flush outranks a same-edge accept, so the bit is simply never taken
   always_comb begin
      acc = accept & ~flush;
      last = acc && cnt == CW'(DATA_W - 1);
      sh_n = LSB_FIRST ? {in_bit, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], in_bit};
      load = last && (!out_valid || out_ready);
      drop = last && out_valid && !out_ready;
      cnt_n = (flush || last) ? '0 : acc ? cnt + 1'b1 : cnt;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         sh <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         overflow <= 1'b0;
         busy <= 1'b0;
      end else begin
         cnt <= cnt_n;
         sh <= flush ? '0 : acc ? sh_n : sh;
         out_data <= load ? sh_n : out_data;
         out_valid <= load || (out_valid && !out_ready);
         overflow <= drop || (overflow && !clear_ovf);
         busy <= cnt_n != '0;
      end
   end
endmodule

// File: rtl/demux4_deser.sv
// demux4_deser: routes a qualified serial bit to one of four channel deserializers
module demux4_deser
   import demux4_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     in_bit,
   input  ch_idx_t                  sel,
   input  logic [NUM_CH-1:0]        flush,
   input  logic [NUM_CH-1:0]        out_ready,
   input  logic [NUM_CH-1:0]        clear_ovf,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_valid,
   output logic [NUM_CH-1:0]        overflow,
   output logic [NUM_CH-1:0]        busy
);
   logic [NUM_CH-1:0] en;
   assign en = in_valid ? sel_onehot(sel) : '0;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      demux4_deser_ch #(.DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_ch (
         .clk(clk),
         .rst_n(rst_n),
         .accept(en[i]),
         .in_bit(in_bit),
         .flush(flush[i]),
         .out_ready(out_ready[i]),
         .clear_ovf(clear_ovf[i]),
         .out_data(out_data[i*DATA_W +: DATA_W]),
         .out_valid(out_valid[i]),
         .overflow(overflow[i]),
         .busy(busy[i])
      );
   end
endmodule

// File: tb/tb_demux4_deser.sv
// tb_demux4_deser: directed stimulus on LSB-first and MSB-first instances against a word-level model
module tb_demux4_deser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic [1:0] sel = 2'd0;
   logic [3:0] flush = 4'd0;
   logic [3:0] out_ready = 4'd0;
   logic [3:0] clear_ovf = 4'd0;
   logic [31:0] data_l, data_m;
   logic [3:0] valid_l, valid_m, ovf_l, ovf_m, busy_l, busy_m;
   int checks = 0;
   int passes = 0;
   bit armed = 1'b0;

   always #5 clk = ~clk;

   demux4_deser #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .sel(sel),
      .flush(flush), .out_ready(out_ready), .clear_ovf(clear_ovf),
      .out_data(data_l), .out_valid(valid_l), .overflow(ovf_l), .busy(busy_l));

   demux4_deser #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .sel(sel),
      .flush(flush), .out_ready(out_ready), .clear_ovf(clear_ovf),
      .out_data(data_m), .out_valid(valid_m), .overflow(ovf_m), .busy(busy_m));

   // model: bits collected in arrival order, word assembled only on completion
   int n [4];
   logic [7:0] got [4];
   logic [7:0] md_l [4];
   logic [7:0] md_m [4];
   logic [3:0] mv, mo, mb;

   always @(posedge clk) begin
      if (!rst_n) begin
         armed = 1'b1;
         mv = '0;
         mo = '0;
         mb = '0;
         for (int c = 0; c < 4; c++) begin
            n[c] = 0;
            got[c] = '0;
            md_l[c] = '0;
            md_m[c] = '0;
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            bit done, xfer;
            logic [7:0] wl, wm;
            done = 1'b0;
            xfer = mv[c] && out_ready[c];
            wl = '0;
            wm = '0;
            if (flush[c]) begin
               n[c] = 0;
               got[c] = '0;
            end else if (in_valid && int'(sel) == c) begin
               got[c][n[c]] = in_bit;
               n[c] = n[c] + 1;
               if (n[c] == 8) begin
                  done = 1'b1;
                  for (int k = 0; k < 8; k++) begin
                     wl[k] = got[c][k];
                     wm[7-k] = got[c][k];
                  end
                  n[c] = 0;
               end
            end
            if (done && (!mv[c] || xfer)) begin
               md_l[c] = wl;
               md_m[c] = wm;
               mv[c] = 1'b1;
               mo[c] = mo[c] && !clear_ovf[c];
            end else begin
               if (xfer) mv[c] = 1'b0;
               mo[c] = done || (mo[c] && !clear_ovf[c]);
            end
            mb[c] = n[c] != 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         passes++;
   endtask

   always @(negedge clk) begin
      if (armed) begin
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("lsb_data%0d", c), 32'(data_l[c*8 +: 8]), 32'(md_l[c]));
            chk($sformatf("msb_data%0d", c), 32'(data_m[c*8 +: 8]), 32'(md_m[c]));
         end
         chk("lsb_valid", 32'(valid_l), 32'(mv));
         chk("msb_valid", 32'(valid_m), 32'(mv));
         chk("lsb_ovf", 32'(ovf_l), 32'(mo));
         chk("msb_ovf", 32'(ovf_m), 32'(mo));
         chk("lsb_busy", 32'(busy_l), 32'(mb));
         chk("msb_busy", 32'(busy_m), 32'(mb));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = '0;
      clear_ovf = '0;
   endtask

   task automatic bit_in(input int c, input logic b);
      in_valid = 1'b1;
      sel = 2'(c);
      in_bit = b;
      cyc();
   endtask

   task automatic send_word(input int c, input logic [7:0] w);
      for (int i = 0; i < 8; i++) bit_in(c, w[i]);
   endtask

   task automatic drain();
      out_ready = 4'hF;
      cyc();
      out_ready = 4'h0;
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'b10100101;
      rst_n = 1'b0;
      cyc();
      cyc();
      chk("rst_valid", 32'(valid_l), 32'h0);
      chk("rst_data", data_l, 32'h0);
      rst_n = 1'b1;
      // basic word on ch2: arrival order 1,0,1,0,0,1,0,1
      for (int i = 0; i < 8; i++) begin
         bit_in(2, pat[7-i]);
         if (i < 7) chk("t1_busy", 32'(busy_l), 32'h4);
      end
      chk("t1_valid", 32'(valid_l), 32'h4);
      chk("t1_data", 32'(data_l[23:16]), 32'hA5);
      chk("t1_msb_data", 32'(data_m[23:16]), 32'hA5);
      chk("t1_busy_end", 32'(busy_l), 32'h0);
      drain();
      chk("t1_drained", 32'(valid_l), 32'h0);
      // interleaved ch0/ch3
      for (int i = 0; i < 8; i++) begin
         logic [7:0] a, b;
         a = 8'h3C;
         b = 8'hC3;
         bit_in(0, a[i]);
         bit_in(3, b[i]);
      end
      chk("t2_valid", 32'(valid_l), 32'h9);
      chk("t2_ch0", 32'(data_l[7:0]), 32'h3C);
      chk("t2_ch3", 32'(data_l[31:24]), 32'hC3);
      drain();
      // overflow on ch1
      send_word(1, 8'h11);
      send_word(1, 8'h22);
      chk("t3_held", 32'(data_l[15:8]), 32'h11);
      chk("t3_ovf", 32'(ovf_l), 32'h2);
      clear_ovf = 4'h2;
      cyc();
      chk("t3_clr", 32'(ovf_l), 32'h0);
      drain();
      // same-edge completion and transfer on ch0
      send_word(0, 8'h55);
      pat = 8'hAA;
      for (int i = 0; i < 7; i++) bit_in(0, pat[i]);
      out_ready = 4'h1;
      bit_in(0, pat[7]);
      out_ready = 4'h0;
      chk("t4_valid", 32'(valid_l[0]), 32'h1);
      chk("t4_data", 32'(data_l[7:0]), 32'hAA);
      chk("t4_ovf", 32'(ovf_l[0]), 32'h0);
      drain();
      // flush with a same-edge accept on ch3
      for (int i = 0; i < 5; i++) bit_in(3, 1'b1);
      flush = 4'h8;
      bit_in(3, 1'b1);
      chk("t5_busy", 32'(busy_l[3]), 32'h0);
      send_word(3, 8'h96);
      chk("t5_word", 32'(data_l[31:24]), 32'h96);
      drain();
      // reset mid-word with a held word
      send_word(2, 8'h5A);
      for (int i = 0; i < 3; i++) bit_in(3, 1'b1);
      rst_n = 1'b0;
      bit_in(3, 1'b1);
      chk("t5_rst_data", data_l, 32'h0);
      chk("t5_rst_flags", {valid_l, ovf_l, busy_l}, 32'h0);
      rst_n = 1'b1;
      // MSB-first instance on ch1, arrival order 1,0,1,0,0,1,0,1
      pat = 8'b10100101;
      for (int i = 0; i < 8; i++) bit_in(1, pat[7-i]);
      chk("t6_msb", 32'(data_m[15:8]), 32'hA5);
      chk("t6_msb_valid", 32'(valid_m), 32'h2);
      drain();
      cyc();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
